// File: rtl/lru_arb_pkg.sv
// Shared types and helpers for the LRU arbiter.
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
//   ARB_N_DEF   : default requester count
//   ARB_N_MAX   : largest supported requester count
//   onehot()    : index -> one-hot vector, ARB_N_MAX bits wide; callers
//                 truncate the result to their own requester count
package lru_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int ARB_N_DEF    = 4;
  localparam int ARB_N_MAX    = 8;
  localparam int ARB_ID_MAX_W = 3;

  function automatic logic [ARB_N_MAX-1:0] onehot(input logic [ARB_ID_MAX_W-1:0] idx);
    logic [ARB_N_MAX-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/lru_rank.sv
// Recency rank store and least-recently-granted search.
// rank_r[i] holds requester i's recency; rank 0 is the least recently granted
// and the ranks always form a permutation of 0..N-1.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset, ranks return to identity
//   upd     in   a grant is being issued this cycle
//   upd_id  in   index of the requester receiving the grant
//   elig    in   N-bit eligibility mask for the search
//   win_id  out  eligible requester with the lowest rank (0 if none)
//   win_vld out  at least one requester is eligible
// The search is purely combinational from the registered ranks.
module lru_rank
  import lru_arb_pkg::*;
#(
  parameter int N = ARB_N_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 upd,
  input  logic [$clog2(N)-1:0] upd_id,
  input  logic [N-1:0]         elig,
  output logic [$clog2(N)-1:0] win_id,
  output logic                 win_vld
);

  localparam int IDW = $clog2(N);

  logic [IDW-1:0] rank_r   [N];
  logic [IDW-1:0] rank_nxt [N];

  // Next ranks: the granted requester moves to the most-recent slot and
  // everything that was more recent than it shifts down by one.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      rank_nxt[j] = rank_r[j];
      if (upd) begin
        if (j == int'(upd_id)) begin
          rank_nxt[j] = IDW'(N - 1);
        end else if (rank_r[j] > rank_r[upd_id]) begin
          rank_nxt[j] = rank_r[j] - IDW'(1);
        end else begin
          rank_nxt[j] = rank_r[j];
        end
      end else begin
        rank_nxt[j] = rank_r[j];
      end
    end
  end

  // Rank registers; reset restores the identity permutation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        rank_r[i] <= IDW'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        rank_r[i] <= rank_nxt[i];
      end
    end
  end

  // Minimum-rank search over eligible requesters. Ranks are unique, so the
  // strict comparison never has to break a tie.
  always_comb begin
    logic [IDW-1:0] best_rank;
    logic           take;
    win_vld   = 1'b0;
    win_id    = '0;
    best_rank = '1;
    take      = 1'b0;
    for (int i = 0; i < N; i++) begin
      take      = elig[i] && (!win_vld || (rank_r[i] < best_rank));
      win_vld   = win_vld | take;
      win_id    = take ? IDW'(i) : win_id;
      best_rank = take ? rank_r[i] : best_rank;
    end
  end

endmodule

// File: rtl/lru_arbiter.sv
// Least-recently-granted arbiter for one shared resource.
// A grant is held until the owner drops its request or until MAX_HOLD timer
// ticks have elapsed; a timed-out owner stays blocked until it drops req.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   tick     in   one-cycle timebase pulse for the hold limit
//   req      in   N request levels, held while using the resource
//   gnt      out  one-hot registered grant, 0 when idle
//   gnt_id   out  index of the current owner, 0 when idle
//   busy     out  high while a grant is active
//   timeout  out  one-cycle pulse when a grant is revoked by the hold limit
//   blocked  out  requesters locked out after a timeout
module lru_arbiter
  import lru_arb_pkg::*;
#(
  parameter int N        = ARB_N_DEF,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout,
  output logic [N-1:0]         blocked
);

  localparam int IDW = $clog2(N);
  localparam int HW  = $clog2(MAX_HOLD + 1);

  arb_state_t     state_r,    state_nxt;
  logic [N-1:0]   gnt_r,      gnt_nxt;
  logic [IDW-1:0] gnt_id_r,   gnt_id_nxt;
  logic           busy_r,     busy_nxt;
  logic           timeout_r,  timeout_nxt;
  logic [N-1:0]   blocked_r,  blocked_nxt;
  logic [HW-1:0]  hold_cnt_r, hold_cnt_nxt;

  logic [N-1:0]   elig_s;
  logic [IDW-1:0] win_id_s;
  logic           win_vld_s;
  logic           upd_s;
  logic           owner_req_s;
  logic           hold_last_s;

  assign elig_s      = req & ~blocked_r;
  assign owner_req_s = req[gnt_id_r];
  assign hold_last_s = (hold_cnt_r == HW'(MAX_HOLD - 1));

  lru_rank #(
    .N (N)
  ) u_rank (
    .clk     (clk),
    .rst     (rst),
    .upd     (upd_s),
    .upd_id  (win_id_s),
    .elig    (elig_s),
    .win_id  (win_id_s),
    .win_vld (win_vld_s)
  );

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_nxt    = state_r;
    gnt_nxt      = gnt_r;
    gnt_id_nxt   = gnt_id_r;
    busy_nxt     = busy_r;
    hold_cnt_nxt = hold_cnt_r;
    timeout_nxt  = 1'b0;
    upd_s        = 1'b0;
    // A dropped request always clears that requester's block, in any state.
    blocked_nxt  = blocked_r & req;

    case (state_r)
      IDLE: begin
        if (win_vld_s) begin
          state_nxt    = GRANT;
          gnt_nxt      = N'(onehot(ARB_ID_MAX_W'(win_id_s)));
          gnt_id_nxt   = win_id_s;
          busy_nxt     = 1'b1;
          hold_cnt_nxt = '0;
          upd_s        = 1'b1;
        end else begin
          state_nxt    = IDLE;
          gnt_nxt      = '0;
          gnt_id_nxt   = '0;
          busy_nxt     = 1'b0;
          hold_cnt_nxt = '0;
        end
      end

      GRANT: begin
        // Release is tested first so that a drop coinciding with the final
        // tick is a clean release: no timeout pulse and no block.
        if (!owner_req_s) begin
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          gnt_id_nxt = '0;
          busy_nxt   = 1'b0;
        end else if (tick) begin
          if (hold_last_s) begin
            state_nxt              = IDLE;
            gnt_nxt                = '0;
            gnt_id_nxt             = '0;
            busy_nxt               = 1'b0;
            timeout_nxt            = 1'b1;
            blocked_nxt[gnt_id_r]  = 1'b1;
          end else begin
            hold_cnt_nxt = hold_cnt_r + HW'(1);
          end
        end else begin
          hold_cnt_nxt = hold_cnt_r;
        end
      end

      default: begin
        state_nxt    = IDLE;
        gnt_nxt      = '0;
        gnt_id_nxt   = '0;
        busy_nxt     = 1'b0;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      gnt_r      <= '0;
      gnt_id_r   <= '0;
      busy_r     <= 1'b0;
      timeout_r  <= 1'b0;
      blocked_r  <= '0;
      hold_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt;
      gnt_r      <= gnt_nxt;
      gnt_id_r   <= gnt_id_nxt;
      busy_r     <= busy_nxt;
      timeout_r  <= timeout_nxt;
      blocked_r  <= blocked_nxt;
      hold_cnt_r <= hold_cnt_nxt;
    end
  end

  assign gnt     = gnt_r;
  assign gnt_id  = gnt_id_r;
  assign busy    = busy_r;
  assign timeout = timeout_r;
  assign blocked = blocked_r;

endmodule

// File: tb/tb_lru_arbiter.sv
// Self-checking bench for lru_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based recency model.
module tb_lru_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic         clk  = 1'b0;
  logic         rst  = 1'b1;
  logic         tick = 1'b0;
  logic [N-1:0] req  = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         busy;
  logic         timeout;
  logic [N-1:0] blocked;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state: owner (-1 = idle), ticks seen in this grant,
  // blocked mask, and recency order (front = least recently granted).
  int           m_owner;
  int           m_ticks;
  logic [N-1:0] m_blocked;
  logic         m_timeout;
  int           m_lru[$];

  always #5 clk = ~clk;

  lru_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout),
    .blocked (blocked)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] rq, input logic tk);
    int           k;
    int           pos;
    logic [N-1:0] nb;
    m_timeout = 1'b0;
    if (r) begin
      m_owner   = -1;
      m_ticks   = 0;
      m_blocked = '0;
      m_lru     = {};
      for (int i = 0; i < N; i++) m_lru.push_back(i);
    end else begin
      nb = m_blocked & rq;
      if (m_owner < 0) begin
        k   = -1;
        pos = 0;
        for (int p = 0; p < m_lru.size(); p++) begin
          if (k < 0 && rq[m_lru[p]] && !m_blocked[m_lru[p]]) begin
            k   = m_lru[p];
            pos = p;
          end
        end
        if (k >= 0) begin
          m_lru.delete(pos);
          m_lru.push_back(k);
          m_owner = k;
          m_ticks = 0;
        end
      end else if (!rq[m_owner]) begin
        m_owner = -1;
      end else if (tk) begin
        m_ticks++;
        if (m_ticks == MAX_HOLD) begin
          m_timeout    = 1'b1;
          nb[m_owner]  = 1'b1;
          m_owner      = -1;
        end
      end
      m_blocked = nb;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] e_gnt;
    e_gnt = '0;
    if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
    check_val("gnt",     32'(gnt),     32'(e_gnt));
    check_val("gnt_id",  32'(gnt_id),  (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    check_val("busy",    32'(busy),    (m_owner >= 0) ? 32'd1 : 32'd0);
    check_val("timeout", 32'(timeout), 32'(m_timeout));
    check_val("blocked", 32'(blocked), 32'(m_blocked));
  endtask

  // One clock: inputs were set at the preceding negedge, model follows the
  // edge, outputs are compared at the next negedge.
  task automatic step();
    @(posedge clk);
    model_step(rst, req, tick);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    m_owner   = -1;
    m_ticks   = 0;
    m_blocked = '0;
    m_timeout = 1'b0;
    for (int i = 0; i < N; i++) m_lru.push_back(i);

    @(negedge clk);

    // Reset held two clocks with every request active.
    rst = 1'b1; req = 4'b1111; tick = 1'b0;
    step();
    step();
    check_val("rst_gnt",     32'(gnt),     32'd0);
    check_val("rst_gnt_id",  32'(gnt_id),  32'd0);
    check_val("rst_busy",    32'(busy),    32'd0);
    check_val("rst_timeout", 32'(timeout), 32'd0);
    check_val("rst_blocked", 32'(blocked), 32'd0);

    // Rotation: owner drops its bit two clocks after each grant.
    rst = 1'b0;
    for (int g = 0; g < N; g++) begin
      step();
      check_val("rot_gnt", 32'(gnt), 32'(1 << g));
      step();
      req[g] = 1'b0;
      step();
      check_val("rot_idle", 32'(gnt), 32'd0);
      req = 4'b1111;
    end

    // LRU order: 2 then 0 alone, then both -> 2 is older.
    req = 4'b0100; step(); check_val("lru_g2", 32'(gnt), 32'h4);
    req = 4'b0000; step();
    req = 4'b0001; step(); check_val("lru_g0", 32'(gnt), 32'h1);
    req = 4'b0000; step();
    req = 4'b0101; step(); check_val("lru_pick", 32'(gnt), 32'h4);
    req = 4'b0000; step();

    // Hold timeout after MAX_HOLD ticks.
    req = 4'b0010; step(); check_val("to_gnt", 32'(gnt), 32'h2);
    for (int t = 0; t < MAX_HOLD; t++) begin
      tick = 1'b1; step();
      tick = 1'b0;
      if (t < MAX_HOLD - 1) step();
    end
    check_val("to_gnt0",    32'(gnt),     32'h0);
    check_val("to_pulse",   32'(timeout), 32'h1);
    check_val("to_blocked", 32'(blocked), 32'h2);
    req = 4'b1010; step();
    check_val("to_other",   32'(gnt),     32'h8);
    check_val("to_pulse1",  32'(timeout), 32'h0);
    req = 4'b0010; step(); check_val("to_still_blk", 32'(blocked), 32'h2);
    req = 4'b0000; step(); check_val("to_unblk",     32'(blocked), 32'h0);
    req = 4'b0010; step(); check_val("to_regrant",   32'(gnt),     32'h2);
    req = 4'b0000; step();

    // Release coinciding with the final tick is a plain release.
    req = 4'b0010; step(); check_val("rt_gnt", 32'(gnt), 32'h2);
    tick = 1'b1;
    for (int t = 0; t < MAX_HOLD - 1; t++) step();
    req = 4'b0000; step();
    tick = 1'b0;
    check_val("rt_timeout", 32'(timeout), 32'h0);
    check_val("rt_blocked", 32'(blocked), 32'h0);
    check_val("rt_busy",    32'(busy),    32'h0);

    // Reset in the middle of a grant restores identity ranks.
    req = 4'b0100; step(); check_val("mr_gnt", 32'(gnt), 32'h4);
    step();
    rst = 1'b1; step(); check_val("mr_drop", 32'(gnt), 32'h0);
    rst = 1'b0; req = 4'b1111; step(); check_val("mr_rank", 32'(gnt), 32'h1);
    req = 4'b0000; step();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      tick = ($urandom_range(0, 2) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
